// File: rtl/shift_arbiter_if.sv
// Request/result bundle for shift_arbiter: two request ports with operands and one tagged result port.
interface shift_arbiter_if;
    localparam int unsigned DW = 8;
    localparam int unsigned NW = 4;

    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_i;
    logic [NW-1:0] req0_n;
    logic          req0_ar;
    logic          req0_lr;
    logic          req0_rot;

    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_i;
    logic [NW-1:0] req1_n;
    logic          req1_ar;
    logic          req1_lr;
    logic          req1_rot;

    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_o;
    logic          res_id;

    modport master (
        output req0_valid, req0_i, req0_n, req0_ar, req0_lr, req0_rot,
        output req1_valid, req1_i, req1_n, req1_ar, req1_lr, req1_rot,
        output res_ready,
        input  req0_ready, req1_ready, res_valid, res_o, res_id
    );

    modport slave (
        input  req0_valid, req0_i, req0_n, req0_ar, req0_lr, req0_rot,
        input  req1_valid, req1_i, req1_n, req1_ar, req1_lr, req1_rot,
        input  res_ready,
        output req0_ready, req1_ready, res_valid, res_o, res_id
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 8-bit shift/rotate unit between two requesters, one registered result stage.
// Optional per-requester drain counters are built when SHIFT_STATS_EN is defined.
module shift_arbiter #(
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic           clk,
    input  logic           nrst,
    shift_arbiter_if.slave bus,
    output logic [15:0]    stat0,
    output logic [15:0]    stat1
);
    localparam int unsigned DW = 8;
    localparam int unsigned NW = 4;
    localparam int unsigned SW = 16;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Rotate uses n mod 8; shifts saturate at 8 (n[3] set) to an all-fill word.
    function automatic logic [DW-1:0] shift_fn(
        input logic [DW-1:0] i,
        input logic [NW-1:0] n,
        input logic          ar,
        input logic          lr,
        input logic          rot
    );
        logic [2*DW-1:0] dbl;
        logic [DW-1:0]   r;
        logic            fill;
        dbl  = {i, i};
        fill = ar & ~lr & i[DW-1];
        r    = i;
        if (rot) begin
            if (lr) begin
                dbl = dbl << n[2:0];
                r   = dbl[2*DW-1:DW];
            end else begin
                dbl = dbl >> n[2:0];
                r   = dbl[DW-1:0];
            end
        end else if (n[NW-1]) begin
            r = {DW{fill}};
        end else if (lr) begin
            r = i << n[2:0];
        end else begin
            r = DW'($signed({fill, i}) >>> n[2:0]);
        end
        return r;
    endfunction

    logic [0:0]    state_q, state_d;
    logic [DW-1:0] res_q, res_d;
    logic          id_q, id_d;
    logic          rr_q, rr_d;
    logic          can_accept;
    logic          grant0;
    logic          grant1;
    logic          accept;

    // Grant: a lone requester wins when the slot frees up; contention goes to the pointer.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || bus.res_ready;
        grant0     = can_accept && bus.req0_valid && (!bus.req1_valid || (rr_q == 1'b0));
        grant1     = can_accept && bus.req1_valid && (!bus.req0_valid || (rr_q == 1'b1));
        accept     = grant0 || grant1;
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        id_d    = id_q;
        rr_d    = rr_q;
        if (grant0) begin
            res_d = shift_fn(bus.req0_i, bus.req0_n, bus.req0_ar, bus.req0_lr, bus.req0_rot);
            id_d  = 1'b0;
            rr_d  = 1'b1;
        end else if (grant1) begin
            res_d = shift_fn(bus.req1_i, bus.req1_n, bus.req1_ar, bus.req1_lr, bus.req1_rot);
            id_d  = 1'b1;
            rr_d  = 1'b0;
        end
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (bus.res_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_EMPTY;
            res_q   <= '0;
            id_q    <= 1'b0;
            rr_q    <= PRIO_RESET;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.res_valid  = (state_q == ST_FULL);
    assign bus.res_o      = res_q;
    assign bus.res_id     = id_q;

`ifdef SHIFT_STATS_EN
    logic [SW-1:0] stat0_q, stat1_q;
    logic          drain;

    assign drain = (state_q == ST_FULL) && bus.res_ready;

    // Count drained results per issuing requester, saturating.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else if (drain) begin
            if (!id_q && (stat0_q != {SW{1'b1}})) stat0_q <= stat0_q + SW'(1);
            if (id_q  && (stat1_q != {SW{1'b1}})) stat1_q <= stat1_q + SW'(1);
        end
    end

    assign stat0 = stat0_q;
    assign stat1 = stat1_q;
`else
    assign stat0 = '0;
    assign stat1 = '0;
`endif
endmodule
